board_ctrl: RTL and testbench

Sequencing controller for the chess board state that the VGA path renders. It owns the 8x8 array of 5-bit square codes and applies host commands: move a piece, set a square, clear the board. Updates are serialized one square access per cycle and start only during vertical blanking, so the video generator never sees a half-applied move within a visible frame. The flattened board output feeds the video generator's `boardPos` input directly.

---
 rtl/board_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_board_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctrl.sv
// board_ctrl
//   Owns the 8x8 chess board (one PIECE_W-bit code per square, 0 = empty)
//   that the VGA path renders. It applies host commands one square access per
//   cycle, and each command starts only during vertical blanking.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   cmd_valid  command presented (held by requester until accepted)
//   cmd_ready  command accepted this cycle (high only in IDLE)
//   cmd_op     00 MOVE, 01 SET, 10 CLEAR_ALL, 11 reserved (rejected)
//   cmd_src    MOVE source square {row[2:0], col[2:0]}
//   cmd_dst    MOVE/SET destination square {row, col}
//   cmd_piece  SET code
//   vblank     display is in vertical blanking
//   board      flattened board, square r*8+c at [(r*8+c)*PIECE_W +: PIECE_W]
//   busy       controller not idle
//   done       one-cycle completion pulse, one per accepted command
//   err        coincident with done when the command was rejected
module board_ctrl #(
  parameter int PIECE_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [5:0]             cmd_src,
  input  logic [5:0]             cmd_dst,
  input  logic [PIECE_W-1:0]     cmd_piece,
  input  logic                   vblank,
  output logic [64*PIECE_W-1:0]  board,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_WR,
    S_CLR,
    S_SWEEP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MOVE  = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  state_t               state_q, state_d;
  state_t               act_state;
  op_t                  op_q, op_d;
  logic [5:0]           src_q, src_d;
  logic [5:0]           dst_q, dst_d;
  logic [PIECE_W-1:0]   tmp_q, tmp_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [PIECE_W-1:0]   board_q [64];

  logic                 wr_en;
  logic [5:0]           wr_addr;
  logic [PIECE_W-1:0]   wr_data;

  // WAIT is left in the same cycle vblank is sampled high: that cycle already
  // performs the first step of the operation (RD, WR or SWEEP), so MOVE reads
  // in the cycle right after the handshake when blanking is already active.
  always_comb begin
    act_state = state_q;
    if (state_q == S_WAIT && vblank) begin
      case (op_q)
        OP_MOVE:  act_state = S_RD;
        OP_SET:   act_state = S_WR;
        OP_CLEAR: act_state = S_SWEEP;
        default:  act_state = S_DONE;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    tmp_d     = tmp_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    wr_addr   = dst_q;
    wr_data   = tmp_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    case (act_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d  = op_t'(cmd_op);
          src_d = cmd_src;
          dst_d = cmd_dst;
          // SET's payload is staged in tmp at accept time, so WR is the same
          // path for SET and MOVE.
          tmp_d = cmd_piece;
          cnt_d = '0;
          if (op_t'(cmd_op) == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        state_d = S_WAIT;
      end

      S_RD: begin
        tmp_d = board_q[src_q];
        if (board_q[src_q] == '0 || src_q == dst_q) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WR;
        end
      end

      S_WR: begin
        wr_en   = 1'b1;
        wr_addr = dst_q;
        wr_data = tmp_q;
        state_d = (op_q == OP_MOVE) ? S_CLR : S_DONE;
      end

      S_CLR: begin
        wr_en   = 1'b1;
        wr_addr = src_q;
        wr_data = '0;
        state_d = S_DONE;
      end

      S_SWEEP: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MOVE;
      src_q   <= '0;
      dst_q   <= '0;
      tmp_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < 64; i++) begin
        board_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      tmp_q   <= tmp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (wr_en) begin
        board_q[wr_addr] <= wr_data;
      end
    end
  end

  always_comb begin
    board = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      board[i*PIECE_W +: PIECE_W] = board_q[i];
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl
//   Directed bench for board_ctrl. A square-level model predicts, for each
//   command, which squares change in which cycle and when done/err fire; a
//   single negedge process compares every output against it each cycle.
module tb_board_ctrl;

  localparam int PW = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'b00;
  logic [5:0]      cmd_src = '0;
  logic [5:0]      cmd_dst = '0;
  logic [PW-1:0]   cmd_piece = '0;
  logic            vblank = 1'b1;
  logic [64*PW-1:0] board;
  logic            busy;
  logic            done;
  logic            err;

  board_ctrl #(.PIECE_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_piece (cmd_piece),
    .vblank    (vblank),
    .board     (board),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Model: visible board contents plus pending square updates keyed by the
  // first cycle in which they must be visible.
  typedef struct {
    int vc;
    int sq;
    int val;
  } ev_t;

  int   mb [64];
  ev_t  evq [$];
  int   done_cyc  = -1;
  bit   exp_err   = 1'b0;
  int   busy_from = -1;

  int   total = 0;
  int   bad   = 0;
  int   last_done = -1;
  bit   last_err  = 1'b0;
  int   busy_cnt  = 0;
  int   done_cnt  = 0;
  int   last_t    = 0;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [64*PW-1:0] packm();
    logic [64*PW-1:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) v[i*PW +: PW] = PW'(mb[i]);
    return v;
  endfunction

  always @(negedge clk) begin
    int k;
    bit in_cmd;
    k = 0;
    while (k < evq.size()) begin
      if (evq[k].vc <= cyc) begin
        mb[evq[k].sq] = evq[k].val;
        evq.delete(k);
      end else begin
        k++;
      end
    end
    in_cmd = (busy_from >= 0) && (cyc > busy_from) && (cyc <= done_cyc);
    chk("board", board, packm());
    chk("done", done, cyc == done_cyc);
    chk("err", err, (cyc == done_cyc) && exp_err);
    chk("busy", busy, in_cmd);
    chk("cmd_ready", cmd_ready, !in_cmd);
    if (done) begin
      last_done = cyc;
      last_err  = err;
      done_cnt++;
    end
    if (busy) busy_cnt++;
  end

  // Call #1 after a posedge with the DUT idle; w = cycles vblank stays low.
  task automatic issue(input logic [1:0] op, input int src, input int dst,
                       input int piece, input int w);
    int t;
    int x;
    ev_t e;
    t = cyc;
    last_t = t;
    chk("ready_at_handshake", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = 6'(src);
    cmd_dst   = 6'(dst);
    cmd_piece = PW'(piece);
    vblank    = (w == 0);
    x = t + 1 + w;
    busy_from = t;
    exp_err   = 1'b0;
    case (op)
      2'b00: begin
        if (mb[src] == 0 || src == dst) begin
          exp_err  = 1'b1;
          done_cyc = x + 1;
        end else begin
          e.vc = x + 2; e.sq = dst; e.val = mb[src]; evq.push_back(e);
          e.vc = x + 3; e.sq = src; e.val = 0;       evq.push_back(e);
          done_cyc = x + 3;
        end
      end
      2'b01: begin
        e.vc = x + 1; e.sq = dst; e.val = piece; evq.push_back(e);
        done_cyc = x + 1;
      end
      2'b10: begin
        for (int i = 0; i < 64; i++) begin
          e.vc = x + 1 + i; e.sq = i; e.val = 0; evq.push_back(e);
        end
        done_cyc = x + 64;
      end
      default: begin
        exp_err  = 1'b1;
        done_cyc = t + 1;
      end
    endcase
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (w) @(posedge clk);
    #1 vblank = 1'b1;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (cyc <= done_cyc && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 500) chk("done_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    evq.delete();
    for (int i = 0; i < 64; i++) mb[i] = 0;
    done_cyc  = -1;
    busy_from = -1;
    exp_err   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64*PW-1:0] zero_board;
    zero_board = '0;
    model_reset();
    #1;
    chk("reset_board", board, zero_board);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", cmd_ready, 1'b1);
    chk("reset_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // SET corner square 0 to all-ones.
    issue(2'b01, 0, 0, 5'h1F, 0);
    wait_done();
    chk("set_sq0_lit", board[4:0], 5'h1F);
    chk("set_latency", last_done - last_t, 2);
    chk("set_err", last_err, 1'b0);

    // SET 9, then MOVE 9 -> 36.
    issue(2'b01, 0, 9, 5'h0C, 0);
    wait_done();
    issue(2'b00, 9, 36, 0, 0);
    wait_done();
    chk("move_sq36_lit", board[36*PW +: PW], 5'h0C);
    chk("move_sq9_lit", board[9*PW +: PW], 5'h00);
    chk("move_latency", last_done - last_t, 4);

    // MOVE 36 -> 7 with vblank low for 100 cycles after the handshake.
    issue(2'b00, 36, 7, 0, 100);
    wait_done();
    chk("vbl_move_sq7_lit", board[7*PW +: PW], 5'h0C);
    chk("vbl_move_latency", last_done - last_t, 104);

    // Rejected commands.
    issue(2'b00, 50, 10, 0, 0);
    wait_done();
    chk("mv_empty_err", last_err, 1'b1);
    chk("mv_empty_latency", last_done - last_t, 2);
    issue(2'b01, 0, 63, 3, 0);
    wait_done();
    issue(2'b00, 63, 63, 0, 0);
    wait_done();
    chk("mv_same_err", last_err, 1'b1);
    chk("mv_same_sq63_lit", board[63*PW +: PW], 5'h03);
    issue(2'b11, 1, 2, 4, 0);
    wait_done();
    chk("rsvd_err", last_err, 1'b1);
    chk("rsvd_latency", last_done - last_t, 1);

    // Fill a few squares, then CLEAR_ALL.
    issue(2'b01, 0, 40, 1, 0);
    wait_done();
    issue(2'b01, 0, 41, 2, 0);
    wait_done();
    busy_cnt = 0;
    done_cnt = 0;
    issue(2'b10, 0, 0, 0, 0);
    wait_done();
    chk("clr_busy_cycles", busy_cnt, 65);
    chk("clr_done_count", done_cnt, 1);
    chk("clr_latency", last_done - last_t, 65);
    chk("clr_board_lit", board, zero_board);

    // Reset in the middle of CLEAR_ALL at sweep counter 20.
    issue(2'b01, 0, 40, 7, 0);
    wait_done();
    issue(2'b01, 0, 63, 9, 0);
    wait_done();
    done_cnt = 0;
    issue(2'b10, 0, 0, 0, 0);
    while (cyc < last_t + 21) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_board", board, zero_board);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ready", cmd_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt, 0);
    issue(2'b01, 0, 5, 4, 0);
    wait_done();
    chk("post_rst_sq5_lit", board[5*PW +: PW], 5'h04);
    chk("post_rst_latency", last_done - last_t, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
